// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - requester/consumer bundle for the 4-channel arbiter
// Four request channels in, one registered data/select output with valid/ready.
interface rr_mux_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             out_ready;

  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  grant, sel, y, y_valid
  );

  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output grant, sel, y, y_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - 4-way round-robin/fixed-priority arbiter with 1-entry output register
// grant is Mealy: it marks the channel whose data is captured into y on this edge.
module rr_mux_arbiter #(
  parameter int WIDTH         = 4,
  parameter int PRIORITY_MODE = 0
) (
  input logic              clk,
  input logic              rst,
  rr_mux_arbiter_if.slave  bus
);

  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       sel_q, sel_d;
  logic             vld_q, vld_d;
  logic [1:0]       ptr_q, ptr_d;

  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             found;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] pick_data;

  always_comb begin
    pick  = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    if (PRIORITY_MODE != 0) begin
      for (int i = 3; i >= 0; i--) begin
        if (bus.req[i]) begin
          pick  = 2'(i);
          found = 1'b1;
        end
      end
    end else begin
      // Search starts just after the last winner; the last winner is tried last.
      for (int k = 1; k <= 4; k++) begin
        idx = ptr_q + 2'(k);
        if (!found && bus.req[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign can_load = !vld_q || bus.out_ready;
  assign load     = can_load && found && !rst;

  always_comb begin
    case (pick)
      2'd0:    pick_data = bus.d0;
      2'd1:    pick_data = bus.d1;
      2'd2:    pick_data = bus.d2;
      default: pick_data = bus.d3;
    endcase
  end

  always_comb begin
    y_d   = y_q;
    sel_d = sel_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (load) begin
      y_d   = pick_data;
      sel_d = pick;
      vld_d = 1'b1;
      ptr_d = pick;
    end else if (vld_q && bus.out_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      sel_q <= 2'b00;
      vld_q <= 1'b0;
      ptr_q <= 2'b11;
    end else begin
      y_q   <= y_d;
      sel_q <= sel_d;
      vld_q <= vld_d;
      ptr_q <= ptr_d;
    end
  end

  assign bus.grant   = load ? (4'b0001 << pick) : 4'b0000;
  assign bus.sel     = sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = vld_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed bench for rr_mux_arbiter, round-robin and fixed-priority instances
// Inputs change 1ns after a rising edge; outputs are sampled 1ns later or 1ns after the next edge.
module tb_rr_mux_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rr_mux_arbiter_if #(.WIDTH(4)) ba ();
  rr_mux_arbiter_if #(.WIDTH(4)) bf ();

  rr_mux_arbiter #(.WIDTH(4), .PRIORITY_MODE(0)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (ba.slave)
  );

  rr_mux_arbiter #(.WIDTH(4), .PRIORITY_MODE(1)) u_fix (
    .clk (clk),
    .rst (rst),
    .bus (bf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_grant [5];
  logic [3:0] exp_y     [5];
  logic [1:0] exp_sel   [5];

  initial begin
    total = 0;
    bad   = 0;
    exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_y     = '{4'hE, 4'hA, 4'h6, 4'hF, 4'hE};
    exp_sel   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst = 1'b1;
    ba.req = 4'b1111; ba.out_ready = 1'b1;
    ba.d0 = 4'hE; ba.d1 = 4'hA; ba.d2 = 4'h6; ba.d3 = 4'hF;
    bf.req = 4'b0000; bf.out_ready = 1'b1;
    bf.d0 = 4'h0; bf.d1 = 4'hA; bf.d2 = 4'h5; bf.d3 = 4'hF;

    // T1 reset held two cycles with all channels requesting
    @(posedge clk); #1;
    check("t1_grant_a", 32'(ba.grant), 32'h0);
    tick();
    check("t1_grant_b", 32'(ba.grant), 32'h0);
    tick();
    check("t1_y", 32'(ba.y), 32'h0);
    check("t1_sel", 32'(ba.sel), 32'h0);
    check("t1_valid", 32'(ba.y_valid), 32'h0);
    rst = 1'b0;
    ba.req = 4'b0000;
    tick();

    // T2 single request on channel 1
    ba.req = 4'b0010;
    #1;
    check("t2_grant", 32'(ba.grant), 32'b0010);
    tick();
    ba.req = 4'b0000;
    #1;
    check("t2_y", 32'(ba.y), 32'hA);
    check("t2_sel", 32'(ba.sel), 32'd1);
    check("t2_valid", 32'(ba.y_valid), 32'h1);
    check("t2_grant_idle", 32'(ba.grant), 32'h0);
    tick();
    check("t2_drained", 32'(ba.y_valid), 32'h0);

    // reset again so the round-robin search restarts at channel 0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // T3 round-robin with all channels requesting, consumer always ready
    ba.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t3_grant_%0d", i), 32'(ba.grant), 32'(exp_grant[i]));
      tick();
      check($sformatf("t3_y_%0d", i), 32'(ba.y), 32'(exp_y[i]));
      check($sformatf("t3_sel_%0d", i), 32'(ba.sel), 32'(exp_sel[i]));
      check($sformatf("t3_valid_%0d", i), 32'(ba.y_valid), 32'h1);
    end

    // T4 back-pressure with channel 2 waiting
    ba.out_ready = 1'b0;
    ba.req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t4_grant_%0d", i), 32'(ba.grant), 32'h0);
      tick();
      check($sformatf("t4_y_%0d", i), 32'(ba.y), 32'hE);
      check($sformatf("t4_sel_%0d", i), 32'(ba.sel), 32'd0);
      check($sformatf("t4_valid_%0d", i), 32'(ba.y_valid), 32'h1);
    end
    ba.out_ready = 1'b1;
    #1;
    check("t4_grant_release", 32'(ba.grant), 32'b0100);
    tick();
    check("t4_y_release", 32'(ba.y), 32'h6);
    check("t4_sel_release", 32'(ba.sel), 32'd2);
    check("t4_valid_release", 32'(ba.y_valid), 32'h1);

    // T6 reset mid-operation discards the held item
    ba.req = 4'b1111;
    rst = 1'b1;
    #1;
    check("t6_grant_rst", 32'(ba.grant), 32'h0);
    tick();
    check("t6_valid_rst", 32'(ba.y_valid), 32'h0);
    check("t6_y_rst", 32'(ba.y), 32'h0);
    rst = 1'b0;
    #1;
    check("t6_grant_first", 32'(ba.grant), 32'b0001);
    tick();
    check("t6_y_first", 32'(ba.y), 32'hE);
    check("t6_sel_first", 32'(ba.sel), 32'd0);
    ba.req = 4'b0000;

    // T5 fixed priority instance
    bf.req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t5_grant_%0d", i), 32'(bf.grant), 32'b0010);
      tick();
      check($sformatf("t5_sel_%0d", i), 32'(bf.sel), 32'd1);
      check($sformatf("t5_y_%0d", i), 32'(bf.y), 32'hA);
    end
    bf.req = 4'b1000;
    #1;
    check("t5_grant_d3", 32'(bf.grant), 32'b1000);
    tick();
    check("t5_sel_d3", 32'(bf.sel), 32'd3);
    check("t5_y_d3", 32'(bf.y), 32'hF);
    bf.req = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
